// File: rtl/fifo_sync_ctl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctl
//
// Single-clock circular-buffer FIFO with an exact occupancy count, run-time
// almost-full / almost-empty thresholds, a selectable read mode (registered
// or first-word-fall-through), a synchronous flush and sticky error flags.
//
// Parameters:
//   DATA_W   - data word width in bits
//   ADDR_W   - address width; DEPTH = 2**ADDR_W words, all usable
//   FWFT     - 0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   RST_DOUT - value loaded into data_out on reset (registered mode only)
//
// Ports:
//   clk          - clock, all logic on the rising edge
//   n_reset      - synchronous, active-high reset (priority over flush)
//   flush        - synchronous clear of contents and sticky flags
//   wr_en        - write request
//   data_in      - write data
//   rd_en        - read request (FWFT: acknowledge of the head word)
//   data_out     - read data
//   data_valid   - data_out qualifier
//   almst_f_thr  - almost-full threshold, legal 1..DEPTH
//   almst_e_thr  - almost-empty threshold, legal 0..DEPTH-1
//   data_count   - number of words held, 0..DEPTH
//   empty        - data_count == 0
//   full         - data_count == DEPTH
//   almst_empty  - data_count <= almst_e_thr
//   almst_full   - data_count >= almst_f_thr
//   overflow     - sticky: a write was rejected
//   underflow    - sticky: a read was rejected
// -----------------------------------------------------------------------------
module fifo_sync_ctl #(
    parameter int                 DATA_W   = 24,
    parameter int                 ADDR_W   = 4,
    parameter bit                 FWFT     = 1'b0,
    parameter logic [DATA_W-1:0]  RST_DOUT = '0
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic [ADDR_W:0]   almst_f_thr,
    input  logic [ADDR_W:0]   almst_e_thr,
    output logic [ADDR_W:0]   data_count,
    output logic              empty,
    output logic              full,
    output logic              almst_empty,
    output logic              almst_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int             DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // Storage. Never reset or cleared: stale words are simply unreachable
    // once the pointers move past them.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic rd_acc;
    logic wr_acc;
    logic mem_we;

    // Status flags are decoded from the count register only, so they never
    // depend combinationally on rd_en/wr_en. Thresholds are live inputs and
    // act on the flags without waiting for a clock edge.
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign almst_empty = (count_q <= almst_e_thr);
    assign almst_full  = (count_q >= almst_f_thr);
    assign data_count  = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Accept decisions. A write into a full FIFO still succeeds when a read
    // frees the head slot in the same cycle; the write lands in that slot
    // while the read sees the old contents. A flush swallows both requests.
    always_comb begin
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (!flush) begin
            rd_acc = rd_en && !empty;
            wr_acc = wr_en && (!full || rd_acc);
        end
    end

    // Reset must not let a pending write touch memory, otherwise the word
    // visible at address 0 after reset in FWFT mode would be corrupted.
    assign mem_we = wr_acc && !n_reset;

    // Next-state for pointers, count and sticky flags. Flush zeroes the
    // bookkeeping and clears the sticky flags; requests made during the
    // flush cycle neither move anything nor count as errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT == 1'b0) begin : g_std
            // Registered read: the head word is captured on an accepted read
            // and qualified for exactly the following cycle; data_out holds
            // its last value otherwise.
            logic [DATA_W-1:0] dout_q, dout_d;
            logic              dvalid_q, dvalid_d;

            always_comb begin
                dout_d   = dout_q;
                dvalid_d = 1'b0;
                if (rd_acc) begin
                    dout_d   = mem_q[rd_ptr_q];
                    dvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (n_reset) begin
                    dout_q   <= RST_DOUT;
                    dvalid_q <= 1'b0;
                end else begin
                    dout_q   <= dout_d;
                    dvalid_q <= dvalid_d;
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dvalid_q;
        end else begin : g_fwft
            // Fall-through: the head slot is always presented and is valid
            // whenever the FIFO holds anything. A read simply advances the
            // pointer so the next word shows up the following cycle.
            assign data_out   = mem_q[rd_ptr_q];
            assign data_valid = !empty;
        end
    endgenerate

endmodule

// File: doc/fifo_sync_ctl.md
Name: fifo_sync_ctl

Overview:
- Parametrised successor to the team's single-clock FIFO: synchronous circular buffer with power-of-two depth and an exact occupancy count.
- Adds run-time almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow flags.
- Sits between streaming producer/consumer blocks in the datapath; replaces fixed-threshold FIFO instances.

Parameters:
- DATA_W, 24, data word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words, all usable
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- RST_DOUT, 0, value loaded into data_out on reset (standard mode only)

Ports:
- clk  input  1  clock, all logic on rising edge
- n_reset  input  1  reset n_reset, synchronous, active-high; clock clk
- flush  input  1  synchronous clear of contents and sticky flags
- wr_en  input  1  write request
- data_in  input  DATA_W  write data
- rd_en  input  1  read request (FWFT: acknowledge of head word)
- data_out  output  DATA_W  read data
- data_valid  output  1  data_out qualifier
- almst_f_thr  input  ADDR_W+1  almost-full threshold, legal 1..DEPTH
- almst_e_thr  input  ADDR_W+1  almost-empty threshold, legal 0..DEPTH-1
- data_count  output  ADDR_W+1  words held, 0..DEPTH
- empty  output  1  data_count == 0
- full  output  1  data_count == DEPTH
- almst_empty  output  1  data_count <= almst_e_thr
- almst_full  output  1  data_count >= almst_f_thr
- overflow  output  1  sticky: a write was rejected
- underflow  output  1  sticky: a read was rejected

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally. data_count is a register of ADDR_W+1 bits.
- Read accept (rd_acc) = rd_en && !empty.
- Write accept (wr_acc) = wr_en && (!full || rd_acc). A write while full is accepted only if a read is also accepted that cycle.
- Count update: wr_acc only -> count+1; rd_acc only -> count-1; both or neither -> unchanged.
- Simultaneous read and write on empty: the read is rejected (underflow set), the write is accepted, count goes to 1.
- empty, full, almst_empty and almst_full are decoded from the data_count register only. There is no combinational path from rd_en or wr_en to any flag. Flags change the cycle after the accepting edge.
- Threshold inputs are sampled continuously; a change is reflected in the flags combinationally from the new threshold value.
- overflow sets when wr_en && !wr_acc. underflow sets when rd_en && !rd_acc. Both hold until flush or reset.
- Standard mode (FWFT=0):
  - data_out <= mem[rd_ptr] on rd_acc; data_valid = 1 for exactly the following cycle.
  - Read latency is 1 cycle. data_out holds its last value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; data_valid = !empty.
  - A word written into an empty FIFO is visible on data_out with data_valid=1 one cycle after the write edge.
  - rd_acc pops the head; the next word appears the following cycle.
- Memory write on wr_acc: mem[wr_ptr] <= data_in. Memory contents are never cleared.
- flush (when n_reset=0): on the next edge, pointers and count go to 0 and overflow/underflow clear. Any rd_en/wr_en in the same cycle are ignored and do not set sticky flags. data_out holds; data_valid goes to 0.
- Reset (n_reset=1) has priority over flush. Values on the next edge:
  - pointers = 0, data_count = 0, empty = 1, full = 0, almst_empty = 1
  - almst_full = 0 for legal thresholds
  - overflow = 0, underflow = 0, data_valid = 0
  - data_out = RST_DOUT (FWFT=0) or mem[0] (FWFT=1, qualified invalid)
- Reset asserted mid-burst discards all contents. The first read after reset release is underflow if no write precedes it.

Test Plan:
- ADDR_W=3, DATA_W=16, FWFT=0: write 8 words 0x0001..0x0008, then 9th write 0x0009 -> full=1, data_count=8, overflow=1, 9th word absent. Read 8 words -> data_out 0x0001..0x0008, each one cycle after rd_en, empty=1 after the last.
- Fill to 8, then assert wr_en+rd_en together for 4 cycles writing 0xA0..0xA3 -> count stays 8, no overflow, reads return 0x0001..0x0004. Pointers wrap, and later reads return 0x0005..0x0008 then 0xA0..0xA3.
- Empty FIFO, wr_en+rd_en same cycle with 0x55 -> underflow=1, data_count=1; next read returns 0x55.
- almst_f_thr=6, almst_e_thr=2: write 6 words -> almst_empty drops on the 3rd write edge+1 and almst_full rises after the 6th. Change almst_f_thr to 7 -> almst_full falls with no clock needed.
- FWFT=1: write 0x1234 into empty -> next cycle data_out=0x1234, data_valid=1. Pulse rd_en -> data_valid=0 the cycle after, empty=1.
- Load 5 words with overflow set, assert flush with wr_en=1 -> count=0, empty=1, overflow=0. Mid-stream n_reset=1 -> all outputs at reset values the next cycle.
